// File: rtl/pipe_regs_fd_de.sv
// Fetch/decode/execute pipeline registers: PC, IF/ID and ID/EX, with stall, flush and bubble handling.
// Optional stall/flush performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_regs_fd_de #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic [31:0]      PCNextF,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  input  logic [31:0]      SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  input  logic [9:0]       CtrlD,
  input  logic             cnt_clr,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             ValidE,
  output logic [31:0]      RD1E,
  output logic [31:0]      RD2E,
  output logic [31:0]      SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [9:0]       CtrlE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcp4_d_q, pcp4_d_d;
  logic        valid_d_q, valid_d_d;
  logic        valid_e_q, valid_e_d;
  logic [31:0] rd1_e_q, rd1_e_d;
  logic [31:0] rd2_e_q, rd2_e_d;
  logic [31:0] imm_e_q, imm_e_d;
  logic [4:0]  rs_e_q, rs_e_d;
  logic [4:0]  rt_e_q, rt_e_d;
  logic [4:0]  rd_e_q, rd_e_d;
  logic [9:0]  ctrl_e_q, ctrl_e_d;

  always_comb begin
    pc_d      = StallF ? pc_q : PCNextF;

    instr_d_d = instr_d_q;
    pcp4_d_d  = pcp4_d_q;
    valid_d_d = valid_d_q;
    if (!StallD) begin
      // A taken branch squashes whatever was fetched behind it.
      instr_d_d = PCSrcD ? 32'h0 : InstrF;
      pcp4_d_d  = PCSrcD ? 32'h0 : PCPlus4F;
      valid_d_d = !PCSrcD;
    end

    valid_e_d = 1'b0;
    rd1_e_d   = 32'h0;
    rd2_e_d   = 32'h0;
    imm_e_d   = 32'h0;
    rs_e_d    = 5'h0;
    rt_e_d    = 5'h0;
    rd_e_d    = 5'h0;
    ctrl_e_d  = 10'h0;
    if (!FlushE) begin
      valid_e_d = valid_d_q;
      rd1_e_d   = RD1D;
      rd2_e_d   = RD2D;
      imm_e_d   = SignImmD;
      rs_e_d    = RsD;
      rt_e_d    = RtD;
      rd_e_d    = RdD;
      ctrl_e_d  = CtrlD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_d_q <= 32'h0;
      pcp4_d_q  <= 32'h0;
      valid_d_q <= 1'b0;
      valid_e_q <= 1'b0;
      rd1_e_q   <= 32'h0;
      rd2_e_q   <= 32'h0;
      imm_e_q   <= 32'h0;
      rs_e_q    <= 5'h0;
      rt_e_q    <= 5'h0;
      rd_e_q    <= 5'h0;
      ctrl_e_q  <= 10'h0;
    end else begin
      pc_q      <= pc_d;
      instr_d_q <= instr_d_d;
      pcp4_d_q  <= pcp4_d_d;
      valid_d_q <= valid_d_d;
      valid_e_q <= valid_e_d;
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      imm_e_q   <= imm_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      rd_e_q    <= rd_e_d;
      ctrl_e_q  <= ctrl_e_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_d_q;
  assign PCPlus4D = pcp4_d_q;
  assign ValidD   = valid_d_q;
  assign ValidE   = valid_e_q;
  assign RD1E     = rd1_e_q;
  assign RD2E     = rd2_e_q;
  assign SignImmE = imm_e_q;
  assign RsE      = rs_e_q;
  assign RtE      = rt_e_q;
  assign RdE      = rd_e_q;
  assign CtrlE    = ctrl_e_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_evt;

  // Counters stick at all-ones so a long stall never reads as a short one.
  always_comb begin
    flush_evt   = FlushE || (PCSrcD && !StallD);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_cnt      = '0;
  assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_regs_fd_de.sv
// Directed bench for pipe_regs_fd_de; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_regs_fd_de;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushE, PCSrcD, cnt_clr;
  logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic [9:0]  CtrlD;
  logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
  logic        ValidD, ValidE;
  logic [4:0]  RsE, RtE, RdE;
  logic [9:0]  CtrlE;
  logic [15:0] stall_cnt, flush_cnt;

  int asserts = 0;
  int fails   = 0;

  pipe_regs_fd_de #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .CtrlD(CtrlD), .cnt_clr(cnt_clr), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .CtrlE(CtrlE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    reset = 0; StallF = 1; StallD = 1; FlushE = 1; PCSrcD = 1; cnt_clr = 0;
    PCNextF = 32'h40; InstrF = 32'hFFFF_FFFF; PCPlus4F = 32'h44;
    RD1D = 32'h1; RD2D = 32'h2; SignImmD = 32'h3; RsD = 5'd1; RtD = 5'd2; RdD = 5'd3;
    CtrlD = 10'h3FF;
    step(); step();
    asserts++; if (PCF !== 32'h0) begin fails++; $display("FAIL reset_pcf got %h want %h", PCF, 32'h0); end
    asserts++; if (ValidD !== 1'b0 || ValidE !== 1'b0) begin fails++; $display("FAIL reset_valid got D=%b E=%b want 0/0", ValidD, ValidE); end
    asserts++; if (CtrlE !== 10'h0 || InstrD !== 32'h0 || RD1E !== 32'h0) begin fails++; $display("FAIL reset_fields got ctrl=%h instr=%h rd1=%h want 0", CtrlE, InstrD, RD1E); end
    asserts++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
    reset = 1; idle_inputs(); InstrF = 32'h0; PCPlus4F = 32'h0; CtrlD = 10'h0;
    step();
    asserts++; if (PCF !== 32'h40) begin fails++; $display("FAIL release_pcf got %h want %h", PCF, 32'h40); end
  endtask

  task automatic test_flow();
    PCNextF = 32'h44; InstrF = 32'h8C22_0004; PCPlus4F = 32'h44;
    RD1D = 32'h11; RD2D = 32'h22; SignImmD = 32'h4; RsD = 5'd1; RtD = 5'd2; RdD = 5'd3;
    CtrlD = 10'h003;
    step();
    asserts++; if (InstrD !== 32'h8C22_0004 || PCPlus4D !== 32'h44 || ValidD !== 1'b1) begin fails++; $display("FAIL flow_ifid got %h/%h/%b want 8c220004/44/1", InstrD, PCPlus4D, ValidD); end
    asserts++; if (PCF !== 32'h44) begin fails++; $display("FAIL flow_pcf got %h want 44", PCF); end
    PCNextF = 32'h48; InstrF = 32'h0000_0020;
    step();
    asserts++; if (ValidE !== 1'b1 || RD1E !== 32'h11 || RD2E !== 32'h22 || SignImmE !== 32'h4) begin fails++; $display("FAIL flow_idex_data got v=%b %h %h %h want 1 11 22 4", ValidE, RD1E, RD2E, SignImmE); end
    asserts++; if (RsE !== 5'd1 || RtE !== 5'd2 || RdE !== 5'd3 || CtrlE !== 10'h003) begin fails++; $display("FAIL flow_idex_ctrl got %0d %0d %0d %h want 1 2 3 003", RsE, RtE, RdE, CtrlE); end
  endtask

  task automatic test_lw_use();
    logic [31:0] pc_before, instr_before;
    pc_before = PCF; instr_before = InstrD;
    StallF = 1; StallD = 1; FlushE = 1;
    PCNextF = 32'h100; InstrF = 32'hDEAD_BEEF; CtrlD = 10'h007;
    step();
    asserts++; if (PCF !== pc_before || InstrD !== instr_before) begin fails++; $display("FAIL lwuse_hold got pc=%h instr=%h want %h %h", PCF, InstrD, pc_before, instr_before); end
    asserts++; if (CtrlE !== 10'h0 || ValidE !== 1'b0 || RD1E !== 32'h0 || RdE !== 5'd0) begin fails++; $display("FAIL lwuse_bubble got ctrl=%h v=%b rd1=%h rd=%0d want 0", CtrlE, ValidE, RD1E, RdE); end
    asserts++; if (ValidD !== 1'b1) begin fails++; $display("FAIL lwuse_validd got %b want 1", ValidD); end
    asserts++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0) || flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin fails++; $display("FAIL lwuse_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, PERF, PERF); end
    idle_inputs();
  endtask

  task automatic test_branch();
    PCSrcD = 1; InstrF = 32'hAAAA_0001; PCPlus4F = 32'h200;
    step();
    asserts++; if (InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin fails++; $display("FAIL branch_squash got %h/%h/%b want 0/0/0", InstrD, PCPlus4D, ValidD); end
    PCSrcD = 0; InstrF = 32'h0000_1234; PCPlus4F = 32'h204;
    step();
    asserts++; if (InstrD !== 32'h1234 || ValidD !== 1'b1) begin fails++; $display("FAIL branch_reload got %h/%b want 1234/1", InstrD, ValidD); end
    PCSrcD = 1; StallD = 1; InstrF = 32'h5555_5555;
    step();
    asserts++; if (InstrD !== 32'h1234 || PCPlus4D !== 32'h204 || ValidD !== 1'b1) begin fails++; $display("FAIL branch_stall_prio got %h/%h/%b want 1234/204/1", InstrD, PCPlus4D, ValidD); end
    asserts++; if (stall_cnt !== (PERF ? 16'd2 : 16'd0) || flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin fails++; $display("FAIL branch_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, PERF ? 2 : 0, PERF ? 2 : 0); end
    idle_inputs();
  endtask

  task automatic test_cnt_sat();
    cnt_clr = 1;
    step();
    asserts++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin fails++; $display("FAIL cnt_clear got %h/%h want 0/0", stall_cnt, flush_cnt); end
    cnt_clr = 0; StallD = 1;
    for (int i = 0; i < 65534; i++) step();
    asserts++; if (stall_cnt !== (PERF ? 16'hFFFE : 16'h0)) begin fails++; $display("FAIL cnt_below_max got %h want %h", stall_cnt, PERF ? 16'hFFFE : 16'h0); end
    for (int i = 0; i < 70000 - 65534; i++) step();
    asserts++; if (stall_cnt !== (PERF ? 16'hFFFF : 16'h0) || flush_cnt !== 16'h0) begin fails++; $display("FAIL cnt_saturate got %h/%h want %h/0", stall_cnt, flush_cnt, PERF ? 16'hFFFF : 16'h0); end
    cnt_clr = 1;
    step();
    asserts++; if (stall_cnt !== 16'h0) begin fails++; $display("FAIL cnt_clr_prio got %h want 0", stall_cnt); end
    cnt_clr = 0; StallD = 0; FlushE = 1;
    step(); step(); step();
    asserts++; if (flush_cnt !== (PERF ? 16'd3 : 16'd0) || ValidE !== 1'b0) begin fails++; $display("FAIL flush_count got %0d v=%b want %0d 0", flush_cnt, ValidE, PERF ? 3 : 0); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_flow();
    test_lw_use();
    test_branch();
    test_cnt_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
